cdc_4phase_tx: RTL and testbench
================================

CDC_4PHASE_TX -- requirements
Module: cdc_4phase_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the transferred word, minimum 1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop count of the internal ack synchronizer; elaboration SHALL fail if below 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1 bit: local producer offers data_i.
REQ-006 SHALL have port ready_o, output, 1 bit: block accepts data_i this cycle.
REQ-007 SHALL have port data_i, input, DATA_WIDTH bits: word to transfer.
REQ-008 SHALL have port async_req_o, output, 1 bit: 4-phase request to the remote receiver, driven directly from a flop.
REQ-009 SHALL have port async_data_o, output, DATA_WIDTH bits: transferred word, driven directly from flops.
REQ-010 SHALL have port async_ack_i, input, 1 bit: 4-phase acknowledge from the remote receiver, asynchronous to clk_i.
REQ-011 SHALL have port busy_o, output, 1 bit: a transfer is in flight (state not IDLE).

Function
REQ-012 SHALL pass async_ack_i through a SYNC_STAGES-deep shift register, reset value 0; ack_s is the last stage, and no other logic SHALL sample async_ack_i.
REQ-013 SHALL implement an FSM with states IDLE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-014 ready_o SHALL be 1 only when state is IDLE and ack_s is 0; it SHALL NOT depend combinationally on valid_i.
REQ-015 Handshake: valid_i & ready_o at an edge SHALL capture data_i into the data register, set the req flop to 1 and move to WAIT_ACK_HI on that edge.
REQ-016 Accept-to-request latency SHALL be 1 cycle: async_req_o and async_data_o are valid in the cycle after the handshake cycle.
REQ-017 In WAIT_ACK_HI, ack_s = 1 at an edge SHALL clear the req flop and move to WAIT_ACK_LO; ack_s = 0 SHALL hold the state.
REQ-018 In WAIT_ACK_LO, ack_s = 0 at an edge SHALL move to IDLE; ack_s = 1 SHALL hold the state.
REQ-019 async_data_o SHALL change only on a handshake edge; between transfers it holds the last word.
REQ-020 valid_i while ready_o = 0 SHALL be ignored; the producer holds the word until accepted.
REQ-021 ack_s rising while in IDLE (spurious or stale ack) SHALL deassert ready_o and SHALL NOT change state or outputs.
REQ-022 Timing with SYNC_STAGES = N: ack rising before edge k gives ack_s = 1 after edge k+N-1 and async_req_o = 0 after edge k+N; the ack falling path has the same delay to IDLE.
REQ-023 Minimum transfer period SHALL be 2N+3 cycles for an ideal zero-delay receiver.
REQ-024 busy_o SHALL be 1 in WAIT_ACK_HI and WAIT_ACK_LO, and 0 in IDLE.

Reset
REQ-025 With rst_i = 1 at an edge, the following SHALL hold regardless of state: state goes to IDLE, async_req_o = 0, async_data_o = 0, synchronizer = all 0, busy_o = 0.
REQ-026 While rst_i = 1, ready_o SHALL be 0; after the first edge with rst_i = 0, ready_o SHALL be 1 if ack_s = 0.
REQ-027 Reset mid-transfer SHALL abort the transfer with no completion indication; the remote receiver must be reset in the same window, and this requirement on the integrator SHALL be documented in the block header.

Verification
REQ-028 Single transfer, N = 2, receiver acks 1 cycle after req and drops ack 1 cycle after req falls, data_i = 32'hDEADBEEF -> async_data_o = DEADBEEF and req high 1 cycle after accept; ready_o returns to 1 after 2N+3 = 7 cycles.
REQ-029 Back-to-back: valid_i held high with words 1, 2, 3 -> exactly three req pulses, async_data_o sequence 1, 2, 3, with no word dropped or duplicated.
REQ-030 Stalled receiver: ack held low for 50 cycles -> req stays 1, data stable, ready_o = 0 and busy_o = 1 throughout; new data_i values are ignored.
REQ-031 Stale ack: async_ack_i forced to 1 in IDLE -> ready_o = 0 after 2 edges and no req; when ack is released, ready_o = 1 after 2 edges.
REQ-032 Reset in WAIT_ACK_HI -> next cycle async_req_o = 0, async_data_o = 0, busy_o = 0, and a following transfer completes normally.
REQ-033 Random receiver ack delays of 0-20 cycles over 1000 transfers -> scoreboard shows received words equal sent words in order, and a protocol checker sees req change only while ack equals req.

Source files
------------

// File: rtl/cdc_4phase_tx.sv
// cdc_4phase_tx: transmit side of a 4-phase req/ack clock-domain crossing.
// A word accepted on the valid/ready handshake is registered onto async_data_o.
// async_req_o is then raised and held until the synchronized acknowledge rises.
// The block returns to IDLE once the acknowledge has fallen again.
//
// Integrator note: reset aborts an in-flight transfer silently. No completion
// is signalled for that transfer. The remote receiver must be reset in the
// same reset window, so that both sides restart from req = ack = 0.
module cdc_4phase_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  async_req_o,
  output logic [DATA_WIDTH-1:0] async_data_o,
  input  logic                  async_ack_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK_HI,
    WAIT_ACK_LO
  } state_t;

  // Reject parameter values the datapath cannot be built with.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cdc_4phase_tx: SYNC_STAGES must be at least 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("cdc_4phase_tx: DATA_WIDTH must be at least 1");
    end
  endgenerate

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ack_s;
  logic                    accept;

  // The synchronizer is the only logic that samples async_ack_i.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_ack_i};
  end

  // ready_o is held low during reset, while busy, and while a stale ack is still high.
  always_comb begin
    ack_s   = sync_q[SYNC_STAGES-1];
    ready_o = !rst_i && (state_q == IDLE) && !ack_s;
    accept  = valid_i && ready_o;
    busy_o  = (state_q != IDLE);
  end

  // Handshake FSM: accept a word, raise req, wait for ack high, drop req, wait for ack low.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // All state, including the outputs driven straight from flops, is cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign async_req_o  = req_q;
  assign async_data_o = data_q;

endmodule

// File: tb/tb_cdc_4phase_tx.sv
// tb_cdc_4phase_tx: directed and randomized-receiver tests for cdc_4phase_tx.
// The DUT is built with N = 2 synchronizer stages.
module tb_cdc_4phase_tx;

  localparam int DW = 32;

  typedef enum int {RX_IDEAL, RX_FORCE, RX_RANDOM} rx_mode_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [DW-1:0] din;
  logic          req;
  logic [DW-1:0] dout;
  logic          ack;
  logic          busy;

  int checks = 0;
  int passed = 0;

  rx_mode_t      rx_mode = RX_FORCE;
  logic          rx_force_val = 1'b0;
  logic          rx_ack_auto = 1'b0;
  int            rx_delay = 0;
  logic          req_seen = 1'b0;
  logic [DW-1:0] rx_q[$];
  bit            proto_en = 1'b0;
  int            proto_err = 0;
  logic          pc_req, pc_ack, pc_rst;

  always #5 clk = ~clk;

  cdc_4phase_tx #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .ready_o     (ready),
    .data_i      (din),
    .async_req_o (req),
    .async_data_o(dout),
    .async_ack_i (ack),
    .busy_o      (busy)
  );

  assign ack = (rx_mode == RX_FORCE) ? rx_force_val : rx_ack_auto;

  // Remote receiver model: ideal mirrors req, random follows req after 0-20 cycles.
  always @(negedge clk) begin
    case (rx_mode)
      RX_IDEAL: rx_ack_auto = (req === 1'b1);
      RX_RANDOM: begin
        if (rx_ack_auto !== req) begin
          if (rx_delay == 0) begin
            rx_ack_auto = req;
            rx_delay = $urandom_range(0, 20);
          end else begin
            rx_delay--;
          end
        end
      end
      default: ;
    endcase
  end

  // Receiver-side capture: record the word each time req rises.
  always @(negedge clk) begin
    if (req === 1'b1 && req_seen !== 1'b1) rx_q.push_back(dout);
    req_seen = req;
  end

  // Protocol monitor: req may only toggle at an edge where ack equals req.
  always @(posedge clk) begin
    pc_req = req;
    pc_ack = ack;
    pc_rst = rst;
    #1;
    if (proto_en && pc_rst !== 1'b1 && req !== pc_req && pc_ack !== pc_req) proto_err++;
  end

  // Global time limit so that the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected completion");
    $display("[TB] %0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer one word starting at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w, input int budget, output bit ok);
    logic was_ready;
    ok = 1'b0;
    valid = 1'b1;
    din = w;
    for (int i = 0; i < budget; i++) begin
      was_ready = ready;
      @(negedge clk);
      if (was_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    valid = 1'b0;
    din = '0;
    rx_mode = RX_FORCE;
    rx_force_val = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", ready); else passed++;
    checks++; if (req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", req); else passed++;
    checks++; if (dout !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 00000000", dout); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", ready); else passed++;
  endtask

  task automatic test_single;
    bit ready_low_ok;
    rx_mode = RX_IDEAL;
    valid = 1'b1;
    din = 32'hDEADBEEF;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (req !== 1'b1) $display("[TB] FAIL single_req_rise: got %b expected 1", req); else passed++;
    checks++; if (dout !== 32'hDEADBEEF) $display("[TB] FAIL single_data: got %h expected deadbeef", dout); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passed++;
    ready_low_ok = (ready === 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++; if (req !== 1'b0) $display("[TB] FAIL single_req_fall: got %b expected 0 at cycle 3", req); else passed++;
      end
      if (i < 6 && ready !== 1'b0) ready_low_ok = 1'b0;
    end
    checks++; if (!ready_low_ok) $display("[TB] FAIL single_ready_low: got ready high early expected low for 6 cycles"); else passed++;
    checks++; if (ready !== 1'b1) $display("[TB] FAIL single_ready_return: got %b expected 1 after 7 cycles", ready); else passed++;
    checks++; if (dout !== 32'hDEADBEEF) $display("[TB] FAIL single_data_hold: got %h expected deadbeef", dout); else passed++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int base;
    int all_ok;
    base = rx_q.size();
    all_ok = 1;
    rx_mode = RX_IDEAL;
    for (int w = 1; w <= 3; w++) begin
      send_word(DW'(w), 50, ok);
      if (!ok) all_ok = 0;
    end
    valid = 1'b0;
    wait_idle(50, ok);
    if (!ok) all_ok = 0;
    checks++; if (all_ok == 0) $display("[TB] FAIL b2b_accept: got timeout expected all words accepted"); else passed++;
    checks++; if (rx_q.size() - base !== 3) $display("[TB] FAIL b2b_pulses: got %0d expected 3", rx_q.size() - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (base + i < rx_q.size()) begin
        checks++; if (rx_q[base+i] !== DW'(i + 1)) $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, rx_q[base+i], i + 1); else passed++;
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    bit stall_ok;
    rx_mode = RX_FORCE;
    rx_force_val = 1'b0;
    send_word(32'hA5A5A5A5, 50, ok);
    checks++; if (!ok) $display("[TB] FAIL stall_accept: got timeout expected accept"); else passed++;
    stall_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      valid = 1'b1;
      din = $urandom;
      @(negedge clk);
      if (req !== 1'b1 || dout !== 32'hA5A5A5A5 || ready !== 1'b0 || busy !== 1'b1) begin
        stall_ok = 1'b0;
        $display("[TB] FAIL stall_cycle%0d: got req=%b data=%h ready=%b busy=%b expected 1/a5a5a5a5/0/1", i, req, dout, ready, busy);
      end
    end
    checks++; if (stall_ok) passed++;
    valid = 1'b0;
    rx_mode = RX_IDEAL;
    wait_idle(50, ok);
    checks++; if (!ok || dout !== 32'hA5A5A5A5) $display("[TB] FAIL stall_complete: got ok=%b data=%h expected 1/a5a5a5a5", ok, dout); else passed++;
  endtask

  task automatic test_stale_ack;
    bit quiet_ok;
    rx_mode = RX_FORCE;
    rx_force_val = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) $display("[TB] FAIL stale_ready_edge1: got %b expected 1", ready); else passed++;
    @(negedge clk);
    checks++; if (ready !== 1'b0) $display("[TB] FAIL stale_ready_edge2: got %b expected 0", ready); else passed++;
    valid = 1'b1;
    din = 32'h55555555;
    quiet_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (req !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || dout !== 32'hA5A5A5A5) quiet_ok = 1'b0;
    end
    checks++; if (!quiet_ok) $display("[TB] FAIL stale_quiet: got req=%b busy=%b ready=%b data=%h expected 0/0/0/a5a5a5a5", req, busy, ready, dout); else passed++;
    valid = 1'b0;
    rx_force_val = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0) $display("[TB] FAIL stale_release_edge1: got %b expected 0", ready); else passed++;
    @(negedge clk);
    checks++; if (ready !== 1'b1) $display("[TB] FAIL stale_release_edge2: got %b expected 1", ready); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int base;
    rx_mode = RX_FORCE;
    rx_force_val = 1'b0;
    send_word(32'h0BADF00D, 50, ok);
    valid = 1'b0;
    checks++; if (!ok || busy !== 1'b1) $display("[TB] FAIL rstmid_enter: got ok=%b busy=%b expected 1/1", ok, busy); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) $display("[TB] FAIL rstmid_ready: got %b expected 0", ready); else passed++;
    @(negedge clk);
    checks++; if (req !== 1'b0 || dout !== 32'h0 || busy !== 1'b0) $display("[TB] FAIL rstmid_clear: got req=%b data=%h busy=%b expected 0/00000000/0", req, dout, busy); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) $display("[TB] FAIL rstmid_ready_after: got %b expected 1", ready); else passed++;
    rx_mode = RX_IDEAL;
    base = rx_q.size();
    send_word(32'h12345678, 50, ok);
    valid = 1'b0;
    if (ok) wait_idle(50, ok);
    checks++;
    if (!ok || rx_q.size() != base + 1 || dout !== 32'h12345678)
      $display("[TB] FAIL rstmid_followup: got ok=%b words=%0d data=%h expected 1/1/12345678", ok, rx_q.size() - base, dout);
    else if (rx_q[base] !== 32'h12345678)
      $display("[TB] FAIL rstmid_followup_word: got %h expected 12345678", rx_q[base]);
    else passed++;
  endtask

  task automatic test_random;
    bit ok;
    int base;
    int perr_base;
    int timeouts;
    int mism;
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] w;
    base = rx_q.size();
    perr_base = proto_err;
    timeouts = 0;
    rx_delay = $urandom_range(0, 20);
    rx_mode = RX_RANDOM;
    proto_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      w = $urandom;
      send_word(w, 200, ok);
      if (ok) tx_q.push_back(w); else timeouts++;
      if ($urandom_range(0, 3) == 0) begin
        valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    valid = 1'b0;
    wait_idle(200, ok);
    if (!ok) timeouts++;
    proto_en = 1'b0;
    checks++; if (timeouts != 0) $display("[TB] FAIL rand_timeouts: got %0d expected 0", timeouts); else passed++;
    checks++; if (rx_q.size() - base != tx_q.size() || tx_q.size() != 1000) $display("[TB] FAIL rand_count: got %0d received of %0d sent expected 1000/1000", rx_q.size() - base, tx_q.size()); else passed++;
    mism = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (base + i >= rx_q.size() || rx_q[base+i] !== tx_q[i]) mism++;
    end
    checks++; if (mism != 0) $display("[TB] FAIL rand_scoreboard: got %0d word errors expected 0", mism); else passed++;
    checks++; if (proto_err - perr_base != 0) $display("[TB] FAIL rand_protocol: got %0d violations expected 0", proto_err - perr_base); else passed++;
  endtask

  initial begin
    $display("[TB] starting cdc_4phase_tx tests");
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_stale_ack();
    test_reset_mid();
    test_random();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
